// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: command codes, FSM states and
// a small command-decode helper.
package bit_serial_alu_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // SUB and SLT run the adder as A + ~B + 1.
  function automatic logic uses_sub(input cmd_e c);
    return (c == CMD_SUB) || (c == CMD_SLT);
  endfunction

  function automatic logic is_arith(input cmd_e c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_slice.sv
// One-bit ALU slice: full adder plus a logic-function mux selected by command.
module alu_bit_slice
  import bit_serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  cmd_e command,
  output logic out,
  output logic cout
);

  logic w_p;
  logic w_g;
  logic w_sum;

  assign w_p   = a ^ b;
  assign w_g   = a & b;
  assign w_sum = w_p ^ cin;
  assign cout  = w_g | (w_p & cin);

  always_comb begin
    out = w_sum;
    case (command)
      CMD_XOR:  out = w_p;
      CMD_AND:  out = w_g;
      CMD_NAND: out = ~w_g;
      CMD_NOR:  out = ~(a | b);
      CMD_OR:   out = a | b;
      default:  out = w_sum;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU controller: streams operands LSB first through one slice,
// assembles the result and flags, and pulses done for one cycle.
module bit_serial_alu
  import bit_serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [2:0]       command,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_shift;
  cmd_e             r_cmd;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carryout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_done;

  logic             w_xfer;
  logic             w_b_bit;
  logic             w_out;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_res;

  assign w_xfer  = (r_state == IDLE) && start_valid;
  assign w_b_bit = r_b[0] ^ uses_sub(r_cmd);

  alu_bit_slice u_slice (
    .a       (r_a[0]),
    .b       (w_b_bit),
    .cin     (r_carry),
    .command (r_cmd),
    .out     (w_out),
    .cout    (w_cout)
  );

  // In the last SHIFT cycle r_carry is the carry into the MSB.
  assign w_final = {w_out, r_shift};
  assign w_ovf   = r_carry ^ w_cout;

  always_comb begin
    w_res = w_final;
    if (r_cmd == CMD_SLT) w_res = {{(WIDTH-1){1'b0}}, w_out ^ w_ovf};
  end

  // Operand and partial-result datapath
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_a     <= operandA;
      r_b     <= operandB;
      r_cmd   <= cmd_e'(command);
      r_shift <= '0;
      r_carry <= uses_sub(cmd_e'(command));
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_shift <= w_final[WIDTH-1:1];
      r_carry <= w_cout;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_cnt      <= '0;
            r_result   <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result   <= w_res;
            r_carryout <= is_arith(r_cmd) & w_cout;
            r_overflow <= is_arith(r_cmd) & w_ovf;
            r_zero     <= (w_res == '0);
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign result      = r_result;
  assign carryout    = r_carryout;
  assign overflow    = r_overflow;
  assign zero        = r_zero;
  assign done        = r_done;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: directed cases, random ops against
// an arithmetic reference model, busy-ignore, mid-operation reset, back-to-back.
module tb_bit_serial_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic [2:0]   command;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;
  logic         done;

  int checks   = 0;
  int failures = 0;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .operandA    (operandA),
    .operandB    (operandB),
    .command     (command),
    .result      (result),
    .carryout    (carryout),
    .overflow    (overflow),
    .zero        (zero),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on whole words.
  function automatic void model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic co, output logic ov, output logic z);
    logic [W:0] s;
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (c)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    z = (r == '0);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Waits for ready, transfers one op, follows it to done. lat = cycles from
  // transfer edge to the cycle where done is seen (-1 on timeout).
  task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic co, output logic ov, output logic z,
                       output int lat, output int busy_bad, output int wait_n);
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!start_ready && wait_n < 100);
    command = c; operandA = a; operandB = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    operandA = W'($urandom); operandB = W'($urandom); command = 3'($urandom);
    lat = 0;
    busy_bad = 0;
    while (lat <= 3 * W) begin
      @(negedge clk); lat++;
      if (done) break;
      if (start_ready || result !== '0 || carryout || overflow || zero) busy_bad++;
    end
    if (!done) lat = -1;
    if (start_ready) busy_bad++;
    r = result; co = carryout; ov = overflow; z = zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b1; operandA = '1; operandB = '1; command = 3'd0;
    repeat (3) @(posedge clk);
    #1 start_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({start_ready, done, carryout, overflow, zero} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy/done/co/ov/z=%b want 10000",
               {start_ready, done, carryout, overflow, zero});
    end
    checks++;
    if (result !== '0) begin
      failures++; $display("FAIL reset_result got=%h want=0", result);
    end
  endtask

  task automatic test_directed();
    logic [2:0]   cmds [6] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd5, 3'd6};
    logic [W-1:0] as   [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'hF0F0F0F0, 32'h0};
    logic [W-1:0] bs   [6] = '{32'h00000001, 32'h00000001, 32'h00000003, 32'h80000000, 32'hFF00FF00, 32'h0};
    logic [W-1:0] rs   [6] = '{32'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0FFF0FFF, 32'hFFFFFFFF};
    logic [2:0]   fl   [6] = '{3'b101, 3'b110, 3'b000, 3'b001, 3'b000, 3'b000};
    logic [W-1:0] r;
    logic co, ov, z;
    int lat, bb, wn;
    for (int i = 0; i < 6; i++) begin
      do_op(cmds[i], as[i], bs[i], r, co, ov, z, lat, bb, wn);
      checks++;
      if (lat !== W + 1) begin
        failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, W + 1);
      end
      checks++;
      if (bb !== 0) begin
        failures++; $display("FAIL dir%0d_busy_outputs got=%0d bad cycles want=0", i, bb);
      end
      checks++;
      if (r !== rs[i]) begin
        failures++; $display("FAIL dir%0d_result got=%h want=%h", i, r, rs[i]);
      end
      checks++;
      if ({co, ov, z} !== fl[i]) begin
        failures++; $display("FAIL dir%0d_flags got co/ov/z=%b want=%b", i, {co, ov, z}, fl[i]);
      end
      @(negedge clk);
      checks++;
      if ({done, start_ready} !== 2'b01 || result !== rs[i]) begin
        failures++;
        $display("FAIL dir%0d_after_done got done/rdy=%b res=%h want 01 res=%h",
                 i, {done, start_ready}, result, rs[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic [2:0] c;
    logic co, ov, z, eco, eov, ez;
    int lat, bb, wn;
    for (int i = 0; i < 120; i++) begin
      c = 3'($urandom); a = pick(); b = pick();
      model(c, a, b, er, eco, eov, ez);
      do_op(c, a, b, r, co, ov, z, lat, bb, wn);
      checks++;
      if (r !== er || {co, ov, z} !== {eco, eov, ez}) begin
        failures++;
        $display("FAIL rand_op cmd=%0d a=%h b=%h got=%h co/ov/z=%b want=%h %b",
                 c, a, b, r, {co, ov, z}, er, {eco, eov, ez});
      end
      checks++;
      if (lat !== W + 1 || bb !== 0) begin
        failures++; $display("FAIL rand_timing got lat=%0d busy_bad=%0d want lat=%0d busy_bad=0", lat, bb, W + 1);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [W-1:0] a, b, er;
    logic eco, eov, ez;
    int lat, bad, n;
    a = W'($urandom); b = W'($urandom);
    model(3'd0, a, b, er, eco, eov, ez);
    n = 0;
    do begin @(negedge clk); n++; end while (!start_ready && n < 100);
    command = 3'd0; operandA = a; operandB = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0; bad = 0;
    while (lat <= 3 * W) begin
      @(negedge clk); lat++;
      if (start_ready) bad++;
      if (done) break;
      if (lat >= 2) begin
        start_valid = 1'b1; command = 3'd1; operandA = W'($urandom); operandB = W'($urandom);
      end
    end
    checks++;
    if (lat !== W + 1 || bad !== 0) begin
      failures++; $display("FAIL busy_ready got lat=%0d ready_high=%0d want lat=%0d ready_high=0", lat, bad, W + 1);
    end
    checks++;
    if (result !== er || {carryout, overflow, zero} !== {eco, eov, ez}) begin
      failures++;
      $display("FAIL busy_result got=%h %b want=%h %b", result, {carryout, overflow, zero}, er, {eco, eov, ez});
    end
    start_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || result !== er) begin
      failures++; $display("FAIL busy_no_second_op got rdy=%b res=%h want rdy=1 res=%h", start_ready, result, er);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] r;
    logic co, ov, z;
    int lat, bb, wn, n, seen;
    n = 0;
    do begin @(negedge clk); n++; end while (!start_ready && n < 100);
    command = 3'd0; operandA = 32'hFFFF_FFFF; operandB = 32'h0000_0001; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({start_ready, done, carryout, overflow, zero} !== 5'b10000 || result !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got rdy/done/co/ov/z=%b res=%h want 10000 res=0",
               {start_ready, done, carryout, overflow, zero}, result);
    end
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || !start_ready) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL midreset_no_done got=%0d busy/done cycles want=0", seen);
    end
    do_op(3'd0, 32'd5, 32'd7, r, co, ov, z, lat, bb, wn);
    checks++;
    if (r !== 32'h0000000C || {co, ov, z} !== 3'b000 || lat !== W + 1) begin
      failures++; $display("FAIL midreset_next_add got=%h %b lat=%0d want=0000000c 000 lat=%0d",
                           r, {co, ov, z}, lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, r, er;
    logic [2:0] c;
    logic co, ov, z, eco, eov, ez;
    int lat, bb, wn;
    for (int i = 0; i < 6; i++) begin
      c = 3'($urandom); a = pick(); b = pick();
      model(c, a, b, er, eco, eov, ez);
      do_op(c, a, b, r, co, ov, z, lat, bb, wn);
      checks++;
      if (r !== er || {co, ov, z} !== {eco, eov, ez}) begin
        failures++;
        $display("FAIL b2b_op%0d cmd=%0d got=%h %b want=%h %b", i, c, r, {co, ov, z}, er, {eco, eov, ez});
      end
      if (i > 0) begin
        checks++;
        if (wn !== 1) begin
          failures++; $display("FAIL b2b_ready_gap%0d got=%0d cycles want=1", i, wn);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_valid = 1'b0; operandA = '0; operandB = '0; command = 3'd0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
